// File: rtl/cycpuf_pkg.sv
// ============================================================================
// Module  : cycpuf_pkg
// Purpose : Shared types and helpers for the cyclic RO PUF evaluation control.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cycpuf_pkg;

  localparam int unsigned CHAL_W_DEF    = 14;
  localparam int unsigned SAMPLE_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_RUN    = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Bits needed to hold values 0..n-1 (never less than one bit).
  function automatic int unsigned width_for(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cycpuf_resp_sync.sv
// ============================================================================
// Module  : cycpuf_resp_sync
// Purpose : Two-flop synchroniser for the asynchronous PUF response bit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cycpuf_resp_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

`default_nettype wire

// File: rtl/cycpuf_eval_ctrl.sv
// ============================================================================
// Module  : cycpuf_eval_ctrl
// Purpose : Runs NUM_EVALS timed PUF evaluations per challenge and votes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cycpuf_eval_ctrl
  import cycpuf_pkg::*;
#(
  parameter int unsigned CHAL_W        = CHAL_W_DEF,
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned NUM_EVALS     = 7,
  parameter int unsigned CNT_W         = width_for(NUM_EVALS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CHAL_W-1:0] i_chal,
  input  logic              i_chal_valid,
  output logic              o_chal_ready,
  input  logic              i_abort,
  output logic [CHAL_W-1:0] o_puf_chal,
  output logic              o_puf_enable,
  output logic              o_puf_reset,
  input  logic              i_puf_resp,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic              o_resp_bit,
  output logic              o_resp_stable,
  output logic [CNT_W-1:0]  o_ones_count,
  output logic              o_busy
);

  localparam int unsigned TMR_MAX0 = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TMR_MAX  = (TMR_MAX0 > SAMPLE_CYCLES) ? TMR_MAX0 : SAMPLE_CYCLES;
  localparam int unsigned TMR_W    = width_for(TMR_MAX);

  localparam logic [TMR_W-1:0] RST_LOAD    = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SAMPLE_LOAD = TMR_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_EVALS   = CNT_W'(NUM_EVALS);
  localparam logic [CNT_W-1:0] CNT_HALF    = CNT_W'(NUM_EVALS / 2);

  if (NUM_EVALS < 1 || (NUM_EVALS % 2) == 0) begin : g_bad_num_evals
    $error("cycpuf_eval_ctrl: NUM_EVALS must be odd and at least 1");
  end
  if (RST_CYCLES < 1 || SETTLE_CYCLES < 1) begin : g_bad_timing
    $error("cycpuf_eval_ctrl: RST_CYCLES and SETTLE_CYCLES must be at least 1");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic [TMR_W-1:0]    r_timer;
  logic [TMR_W-1:0]    w_timer_nxt;
  logic [CNT_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_ones;
  logic [CNT_W-1:0]    w_idx_inc;
  logic [CNT_W-1:0]    w_ones_inc;
  logic [CHAL_W-1:0]   r_chal;
  logic                r_resp_bit;
  logic                r_resp_stable;
  logic                w_sync;
  logic                w_accept;
  logic                w_abort;
  logic                w_sample_done;

  cycpuf_resp_sync u_resp_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (i_puf_resp),
    .o_sync  (w_sync)
  );

  assign w_idx_inc  = r_idx + CNT_W'(1);
  assign w_ones_inc = r_ones + CNT_W'(w_sync);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_sample_done = 1'b0;
    w_abort       = i_abort && (r_state != ST_IDLE);
    o_chal_ready  = 1'b0;
    o_puf_enable  = 1'b0;
    o_puf_reset   = 1'b1;
    o_resp_valid  = 1'b0;
    o_busy        = 1'b1;

    case (r_state)
      ST_IDLE: begin
        o_chal_ready = 1'b1;
        o_busy       = 1'b0;
        if (i_chal_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (r_timer == '0) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        o_puf_reset  = 1'b0;
        o_puf_enable = 1'b1;
        if (r_timer == '0) w_state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        o_puf_reset  = 1'b0;
        o_puf_enable = 1'b1;
        if (r_timer == '0) begin
          w_sample_done = 1'b1;
          w_state_nxt   = (w_idx_inc < CNT_EVALS) ? ST_CLEAR : ST_DONE;
        end
      end
      ST_DONE: begin
        o_resp_valid = 1'b1;
        if (i_resp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_abort) begin
      w_state_nxt   = ST_IDLE;
      w_sample_done = 1'b0;
    end

    // Each phase preloads its own length on entry and counts down to zero.
    w_timer_nxt = r_timer;
    if (w_state_nxt != r_state) begin
      case (w_state_nxt)
        ST_CLEAR:  w_timer_nxt = RST_LOAD;
        ST_RUN:    w_timer_nxt = SETTLE_LOAD;
        ST_SAMPLE: w_timer_nxt = SAMPLE_LOAD;
        default:   w_timer_nxt = '0;
      endcase
    end else if (r_timer != '0) begin
      w_timer_nxt = r_timer - TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer       <= '0;
      r_idx         <= '0;
      r_ones        <= '0;
      r_chal        <= '0;
      r_resp_bit    <= 1'b0;
      r_resp_stable <= 1'b0;
    end else begin
      r_timer <= w_timer_nxt;
      if (w_accept) r_chal <= i_chal;
      if (w_accept || w_abort) begin
        r_ones <= '0;
        r_idx  <= '0;
      end else if (w_sample_done) begin
        r_ones <= w_ones_inc;
        r_idx  <= w_idx_inc;
        if (w_state_nxt == ST_DONE) begin
          r_resp_bit    <= (w_ones_inc > CNT_HALF);
          r_resp_stable <= (w_ones_inc == '0) || (w_ones_inc == CNT_EVALS);
        end
      end
    end
  end

  assign o_puf_chal    = r_chal;
  assign o_ones_count  = r_ones;
  assign o_resp_bit    = r_resp_bit;
  assign o_resp_stable = r_resp_stable;

endmodule

`default_nettype wire

// File: tb/tb_cycpuf_eval_ctrl.sv
// ============================================================================
// Module  : tb_cycpuf_eval_ctrl
// Purpose : Self-checking bench for cycpuf_eval_ctrl against a timeline model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cycpuf_eval_ctrl;

  localparam int R  = 4;
  localparam int S  = 64;
  localparam int N  = 7;
  localparam int T  = R + S + 2;
  localparam int NT = N * T;
  localparam int CW = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [CW-1:0] chal;
  logic          chal_valid, abort, resp_ready;
  logic          puf_resp = 1'b0;
  logic          chal_ready, puf_enable, puf_reset, resp_valid, resp_bit, resp_stable, busy;
  logic [CW-1:0] puf_chal;
  logic [2:0]    ones_count;

  logic          s_chal_valid, s_resp_ready, s_abort;
  logic          s_puf_resp;
  logic [CW-1:0] s_chal;
  logic          s_chal_ready, s_puf_enable, s_puf_reset, s_resp_valid, s_resp_bit, s_resp_stable, s_busy;
  logic [CW-1:0] s_puf_chal;
  logic [0:0]    s_ones_count;

  cycpuf_eval_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .i_chal(chal), .i_chal_valid(chal_valid),
    .o_chal_ready(chal_ready), .i_abort(abort), .o_puf_chal(puf_chal),
    .o_puf_enable(puf_enable), .o_puf_reset(puf_reset), .i_puf_resp(puf_resp),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_resp_bit(resp_bit),
    .o_resp_stable(resp_stable), .o_ones_count(ones_count), .o_busy(busy)
  );

  cycpuf_eval_ctrl #(.RST_CYCLES(1), .SETTLE_CYCLES(1), .NUM_EVALS(1)) u_dut_small (
    .clk(clk), .rst_n(rst_n), .i_chal(s_chal), .i_chal_valid(s_chal_valid),
    .o_chal_ready(s_chal_ready), .i_abort(s_abort), .o_puf_chal(s_puf_chal),
    .o_puf_enable(s_puf_enable), .o_puf_reset(s_puf_reset), .i_puf_resp(s_puf_resp),
    .o_resp_valid(s_resp_valid), .i_resp_ready(s_resp_ready), .o_resp_bit(s_resp_bit),
    .o_resp_stable(s_resp_stable), .o_ones_count(s_ones_count), .o_busy(s_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: time since accept determines the phase of every evaluation.
  logic [6:0]    pat;
  bit            chk_en;
  bit            m_busy, m_done, m_bit, m_stable;
  int            m_t, m_ones;
  logic [CW-1:0] m_chal;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_t = 0; m_ones = 0;
      m_chal = '0; m_bit = 0; m_stable = 0;
    end else if (m_busy || m_done) begin
      if (abort) begin
        m_busy = 0; m_done = 0; m_ones = 0;
      end else if (m_done) begin
        if (resp_ready) m_done = 0;
      end else begin
        m_t++;
        if (m_t % T == 0) m_ones += int'(pat[m_t / T - 1]);
        if (m_t == NT) begin
          m_busy   = 0;
          m_done   = 1;
          m_bit    = (m_ones > N / 2);
          m_stable = (m_ones == 0) || (m_ones == N);
        end
      end
    end else if (chal_valid) begin
      m_busy = 1; m_t = 0; m_chal = chal; m_ones = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("chal_ready", chal_ready, !(m_busy || m_done));
      chk("busy",       busy,       m_busy || m_done);
      chk("resp_valid", resp_valid, m_done);
      chk("puf_reset",  puf_reset,  m_busy ? ((m_t % T) < R) : 1'b1);
      chk("puf_enable", puf_enable, m_busy ? ((m_t % T) >= R) : 1'b0);
      chk("puf_chal",   puf_chal,   m_chal);
      chk("ones_count", ones_count, m_ones);
      chk("resp_bit",   resp_bit,   m_bit);
      chk("resp_stable", resp_stable, m_stable);
    end
    // Behavioural PUF: one constant response bit per evaluation.
    puf_resp = (m_busy && m_t < NT) ? pat[m_t / T] : 1'b0;
  end

  task automatic start_txn(input logic [CW-1:0] c, input logic [6:0] p);
    int w = 0;
    while (!chal_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_accept", chal_ready, 1);
    chal = c;
    pat = p;
    chal_valid = 1;
    @(negedge clk);
    chal_valid = 0;
    chk("ready_drop", chal_ready, 0);
    chk("chal_latched", puf_chal, c);
  endtask

  task automatic run_txn(input logic [CW-1:0] c, input logic [6:0] p, input int hold,
                         input int abort_at, input bit poke, input bit directed);
    int lat = 0, en_c = 0, rs_c = 0, seen = 0;
    bit aborted = 0;
    start_txn(c, p);
    while (!resp_valid && !aborted && lat < 2000) begin
      en_c += int'(puf_enable);
      rs_c += int'(puf_reset);
      if (lat == abort_at) begin
        abort = 1;
        @(negedge clk);
        abort = 0;
        aborted = 1;
        chk("abort_idle",   chal_ready, 1);
        chk("abort_reset",  puf_reset, 1);
        chk("abort_enable", puf_enable, 0);
        chk("abort_ones",   ones_count, 0);
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    if (aborted) begin
      repeat (NT + 10) begin
        @(negedge clk);
        if (resp_valid) seen++;
      end
      chk("no_resp_after_abort", seen, 0);
      return;
    end
    chk("resp_timeout", (lat < 2000), 1);
    if (directed) begin
      chk("latency", lat, NT);
      chk("enable_cycles", en_c, N * (S + 2));
      chk("reset_cycles", rs_c, N * R);
    end
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        chal = ~c;
        chal_valid = 1;
      end
      @(negedge clk);
    end
    chal_valid = 0;
    chk("valid_held", resp_valid, 1);
    chk("chal_unchanged", puf_chal, c);
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    chk("idle_after_ready", chal_ready, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [6:0] rp;
    rst_n = 0; chal = '0; chal_valid = 0; abort = 0; resp_ready = 0; pat = '0; chk_en = 0;
    s_chal = '0; s_chal_valid = 0; s_resp_ready = 0; s_abort = 0; s_puf_resp = 0;
    repeat (3) @(negedge clk);
    chk("rst_puf_reset",  puf_reset, 1);
    chk("rst_puf_enable", puf_enable, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_ones",       ones_count, 0);
    chk("rst_busy",       busy, 0);
    rst_n = 1;
    @(negedge clk);
    chk_en = 1;

    // Minimal configuration: one evaluation of 1+1+2 cycles, response 0.
    chk("small_ready", s_chal_ready, 1);
    s_chal = 14'h1234;
    s_chal_valid = 1;
    @(negedge clk);
    s_chal_valid = 0;
    lat = 0;
    while (!s_resp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("small_latency", lat, 4);
    chk("small_bit", s_resp_bit, 0);
    chk("small_stable", s_resp_stable, 1);
    chk("small_ones", s_ones_count, 0);
    chk("small_chal", s_puf_chal, 14'h1234);
    s_resp_ready = 1;
    @(negedge clk);
    s_resp_ready = 0;
    chk("small_idle", s_chal_ready, 1);

    run_txn(14'h2A5C, 7'b1111111, 0, -1, 0, 1);
    chk("t1_ones", m_ones, 7);
    run_txn(14'h1357, 7'b1001101, 0, -1, 0, 1);
    chk("t2_ones", m_ones, 4);
    chk("t2_bit", m_bit, 1);
    chk("t2_stable", m_stable, 0);
    run_txn(14'h0F0F, 7'b0000100, 20, -1, 1, 1);
    chk("t3_bit", m_bit, 0);
    run_txn(14'h3333, 7'b1111111, 0, 2 * T + R + 10, 0, 0);

    // Asynchronous reset in the middle of the second evaluation's sample window.
    start_txn(14'h2222, 7'b1111111);
    repeat (T + R + S) @(negedge clk);
    chk("pre_rst_sample", puf_enable, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_puf_reset",  puf_reset, 1);
    chk("arst_enable",     puf_enable, 0);
    chk("arst_valid",      resp_valid, 0);
    chk("arst_busy",       busy, 0);
    chk("arst_chal",       puf_chal, 0);
    chk("arst_ones",       ones_count, 0);
    chk("arst_stable",     resp_stable, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run_txn(14'h0ABC, 7'b0110010, 2, -1, 0, 1);

    for (int k = 0; k < 10; k++) begin
      rp = 7'($urandom);
      run_txn(14'($urandom), rp, $urandom_range(0, 6),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NT - 1)) : -1,
              1'($urandom_range(0, 1)), 1);
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
